adxl362_fifo_ctrl: RTL and testbench

Mode-aware sample FIFO for the ADXL362 behavioral model. It generalises the plain 512-entry FIFO with parametrised width and depth, an occupancy count, a watermark flag and a sticky overrun flag. It implements the four ADXL362 FIFO modes: disabled, oldest-saved, stream and triggered. It sits between the sample generator (write side) and the SPI register/readout logic (read side).

---
 rtl/adxl362_pkg.sv | 13 +
 rtl/adxl362_fifo_ram.sv | 25 ++
 rtl/adxl362_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_adxl362_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_pkg.sv
// Shared definitions for the ADXL362 sample FIFO: mode encodings and width.
package adxl362_pkg;

  localparam int MODE_WIDTH = 2;

  typedef enum logic [MODE_WIDTH-1:0] {
    FIFO_DISABLED  = 2'd0,
    FIFO_OLDEST    = 2'd1,
    FIFO_STREAM    = 2'd2,
    FIFO_TRIGGERED = 2'd3
  } fifo_mode_e;

endpackage

// File: rtl/adxl362_fifo_ram.sv
// Sample storage: synchronous write port, combinational read port.
// Contents are never cleared; validity is tracked by the controller.
module adxl362_fifo_ram #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 512,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [INDEX_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming sample at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adxl362_fifo_ctrl.sv
// Mode-aware sample FIFO: pointers, occupancy count, watermark, sticky
// overrun and trigger flags, and the four ADXL362 FIFO modes.
//
// Handshake: write/read are single-cycle strobes with no back-pressure.
// A strobe is accepted on the rising edge where it is sampled high, unless
// reset, flush or a mode change owns that edge; the effect is visible on
// count/flags/data_read right after that edge.
module adxl362_fifo_ctrl
  import adxl362_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 512,
  parameter int INDEX_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH   = INDEX_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MODE_WIDTH-1:0] mode,
  input  logic [CNT_WIDTH-1:0]  watermark,
  input  logic                  flush,
  input  logic                  write,
  input  logic [WIDTH-1:0]      data_write,
  input  logic                  read,
  input  logic                  trigger,
  input  logic                  ovr_clear,
  output logic [WIDTH-1:0]      data_read,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  wm,
  output logic                  overrun,
  output logic                  triggered
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  fifo_mode_e             mode_in;
  fifo_mode_e             mode_q;
  logic [INDEX_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ovr_q, trig_q;

  logic                   clear;
  logic                   rd_ok, wr_req, at_limit, oldest_like;
  logic                   push, pop, ovr_set, trig_accept;
  logic [CNT_WIDTH-1:0]   cap;

  assign mode_in = fifo_mode_e'(mode);

  // Decide which pointers move this edge and whether an overrun occurs.
  always_comb begin
    clear       = flush | (mode_in != mode_q);
    rd_ok       = (mode_q != FIFO_DISABLED) & read & (cnt_q != '0);
    wr_req      = (mode_q != FIFO_DISABLED) & write;
    oldest_like = (mode_q == FIFO_OLDEST) | ((mode_q == FIFO_TRIGGERED) & trig_q);
    // Pre-trigger history depth; an unset or oversize watermark means the whole array.
    cap         = ((watermark == '0) || (watermark > DEPTH_C)) ? DEPTH_C : watermark;
    at_limit    = ((mode_q == FIFO_TRIGGERED) & ~trig_q) ? (cnt_q >= cap)
                                                         : (cnt_q == DEPTH_C);
    push        = 1'b0;
    pop         = rd_ok;
    ovr_set     = 1'b0;
    if (wr_req) begin
      if (!at_limit || rd_ok) begin
        push = 1'b1;
      end else if (oldest_like) begin
        ovr_set = 1'b1;
      end else begin
        // Overwrite the oldest entry; only a true stream overflow is an overrun.
        push    = 1'b1;
        pop     = 1'b1;
        ovr_set = (mode_q == FIFO_STREAM);
      end
    end
    trig_accept = (mode_q == FIFO_TRIGGERED) & trigger & ~trig_q;
  end

  // Pointer, count, flag and mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= mode_in;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      trig_q   <= 1'b0;
    end else if (clear) begin
      mode_q   <= mode_in;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + INDEX_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + INDEX_WIDTH'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_WIDTH'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_WIDTH'(1);
      ovr_q <= ovr_set | (ovr_q & ~ovr_clear);
      if (trig_accept) trig_q <= 1'b1;
    end
  end

  adxl362_fifo_ram #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & ~clear & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_write),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_read)
  );

  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == DEPTH_C);
  assign wm        = (watermark != '0) & (cnt_q >= watermark);
  assign overrun   = ovr_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_adxl362_fifo_ctrl.sv
// Directed and randomized checks of adxl362_fifo_ctrl against a queue model.
module tb_adxl362_fifo_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       mode = 2'd1;
  logic [CW-1:0]    watermark = '0;
  logic             flush = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] data_write = '0;
  logic             read = 1'b0;
  logic             trigger = 1'b0;
  logic             ovr_clear = 1'b0;
  logic [WIDTH-1:0] data_read;
  logic [CW-1:0]    count;
  logic             empty, full, wm, overrun, triggered;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_ovr  = 0;
  bit               m_trig = 0;
  logic [1:0]       m_mode = 2'd0;

  adxl362_fifo_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .watermark(watermark), .flush(flush),
    .write(write), .data_write(data_write), .read(read), .trigger(trigger),
    .ovr_clear(ovr_clear), .data_read(data_read), .count(count), .empty(empty),
    .full(full), .wm(wm), .overrun(overrun), .triggered(triggered)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: apply the current strobes as one clock edge, FIFO as a plain queue.
  task automatic model_edge();
    int  n;
    int  limit;
    bit  took_rd;
    bit  ovr_ev;
    bit  active;
    if (rst || flush || (mode != m_mode)) begin
      mq.delete();
      m_ovr  = 0;
      m_trig = 0;
      m_mode = mode;
      return;
    end
    n       = mq.size();
    active  = (m_mode != 2'd0);
    took_rd = active && read && (n > 0);
    ovr_ev  = 0;
    if (m_mode == 2'd3 && !m_trig)
      limit = (watermark == 0 || int'(watermark) > DEPTH) ? DEPTH : int'(watermark);
    else
      limit = DEPTH;
    if (took_rd) void'(mq.pop_front());
    if (active && write) begin
      if (n < limit || took_rd) begin
        mq.push_back(data_write);
      end else if (m_mode == 2'd1 || (m_mode == 2'd3 && m_trig)) begin
        ovr_ev = 1;
      end else begin
        void'(mq.pop_front());
        mq.push_back(data_write);
        if (m_mode == 2'd2) ovr_ev = 1;
      end
    end
    if (m_mode == 2'd3 && trigger) m_trig = 1;
    m_ovr = ovr_ev || (m_ovr && !ovr_clear);
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("wm", 32'(wm), 32'((watermark != 0) && (n >= int'(watermark))));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("triggered", 32'(triggered), 32'(m_trig));
    if (n > 0) chk("data_read", 32'(data_read), 32'(mq[0]));
  endtask

  // One edge: model the edge, sample 1 ns later, then drop all strobes.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rst = 0; flush = 0; write = 0; read = 0; trigger = 0; ovr_clear = 0;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    write = 1; data_write = d; tick();
  endtask

  task automatic rd();
    read = 1; tick();
  endtask

  logic [WIDTH-1:0] trig_exp [8];

  initial begin
    trig_exp[0] = 16'h13; trig_exp[1] = 16'h14; trig_exp[2] = 16'h15;
    trig_exp[3] = 16'h20; trig_exp[4] = 16'h21; trig_exp[5] = 16'h22;
    trig_exp[6] = 16'h23; trig_exp[7] = 16'h24;

    // Reset state
    rst = 1; mode = 2'd1; tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_flags", 32'({full, wm, overrun, triggered}), 0);

    // Oldest-saved overflow
    for (int i = 1; i <= 9; i++) wr(16'(i));
    chk("old_count", 32'(count), 8);
    chk("old_full", 32'(full), 1);
    chk("old_ovr", 32'(overrun), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("old_rd", 32'(data_read), 32'(i));
      rd();
    end
    chk("old_empty", 32'(empty), 1);

    // Stream overflow
    mode = 2'd2; tick();
    for (int i = 1; i <= 10; i++) wr(16'(i));
    chk("str_count", 32'(count), 8);
    chk("str_ovr", 32'(overrun), 1);
    for (int i = 3; i <= 10; i++) begin
      chk("str_rd", 32'(data_read), 32'(i));
      rd();
    end

    // Overrun clear, and set winning over clear
    for (int i = 0; i < 9; i++) wr(16'h100 + 16'(i));
    ovr_clear = 1; tick();
    chk("ovr_clr", 32'(overrun), 0);
    ovr_clear = 1; write = 1; data_write = 16'h1FF; tick();
    chk("ovr_set_wins", 32'(overrun), 1);

    // Triggered mode
    mode = 2'd3; watermark = 3; tick();
    for (int i = 16'h10; i <= 16'h15; i++) wr(16'(i));
    chk("trg_pre_ovr", 32'(overrun), 0);
    trigger = 1; tick();
    for (int i = 16'h20; i <= 16'h2F; i++) wr(16'(i));
    trigger = 1; tick();
    chk("trg_flag", 32'(triggered), 1);
    chk("trg_count", 32'(count), 8);
    chk("trg_ovr", 32'(overrun), 1);
    for (int i = 0; i < 8; i++) begin
      chk("trg_rd", 32'(data_read), 32'(trig_exp[i]));
      rd();
    end

    // Watermark
    mode = 2'd1; watermark = 4; tick();
    for (int i = 1; i <= 4; i++) begin
      wr(16'h40 + 16'(i));
      chk("wm_level", 32'(wm), 32'(i >= 4));
    end
    rd();
    chk("wm_fall", 32'(wm), 0);
    watermark = 0; tick();
    chk("wm_zero", 32'(wm), 0);

    // Simultaneous read+write at full, then read at empty
    flush = 1; tick();
    for (int i = 0; i < 8; i++) wr(16'h50 + 16'(i));
    write = 1; data_write = 16'h5A; read = 1; tick();
    chk("rw_full_count", 32'(count), 8);
    chk("rw_full_ovr", 32'(overrun), 0);
    for (int i = 0; i < 8; i++) rd();
    rd();
    chk("rd_empty", 32'(count), 0);

    // Mode change mid-fill, reset mid-burst
    for (int i = 0; i < 5; i++) wr(16'h60 + 16'(i));
    chk("mid_count", 32'(count), 5);
    mode = 2'd2; write = 1; data_write = 16'h6F; tick();
    chk("mchg_count", 32'(count), 0);
    chk("mchg_flags", 32'({overrun, triggered}), 0);
    for (int i = 0; i < 3; i++) wr(16'h70 + 16'(i));
    rst = 1; write = 1; data_write = 16'h7F; tick();
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_empty", 32'(empty), 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) watermark = CW'($urandom_range(0, 10));
      flush      = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      trigger    = ($urandom_range(0, 29) == 0);
      ovr_clear  = ($urandom_range(0, 19) == 0);
      write      = ($urandom_range(0, 9) < 6);
      read       = ($urandom_range(0, 9) < 4);
      data_write = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
